// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush controller
package pipe_ctrl_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam int STG_PC  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EXE = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

   localparam int DEF_NUM_STAGES    = 5;
   localparam int DEF_PC_W          = 32;
   localparam int DEF_FLUSH_HOLD    = 1;
   localparam int DEF_STALL_TIMEOUT = 1023;

endpackage

// File: rtl/pipe_ctrl_prio_enc.sv
// rtl/pipe_ctrl_prio_enc.sv - highest-index priority encoder picking the oldest flushing stage
module pipe_ctrl_prio_enc
   import pipe_ctrl_pkg::*;
#(
   parameter int N  = DEF_NUM_STAGES,
   parameter int IW = $clog2(DEF_NUM_STAGES)
)(
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            idx   = IW'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - per-stage stall/bubble/flush controller with flush hold and stall timeout
// Optional perf counters enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int NUM_STAGES    = DEF_NUM_STAGES,
   parameter int PC_W          = DEF_PC_W,
   parameter int FLUSH_HOLD    = DEF_FLUSH_HOLD,
   parameter int STALL_TIMEOUT = DEF_STALL_TIMEOUT
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_STAGES-1:0]      stallreq,
   input  logic [NUM_STAGES-1:0]      flush_req,
   input  logic [NUM_STAGES*PC_W-1:0] flush_pc_in,
   output logic [NUM_STAGES-1:0]      stall,
   output logic [NUM_STAGES-1:0]      bubble,
   output logic [NUM_STAGES-1:0]      flush,
   output logic                       redirect_valid,
   output logic [PC_W-1:0]            redirect_pc,
   output logic                       stall_timeout
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]                perf_stall_cycles,
   output logic [31:0]                perf_flush_count
`endif
);

   localparam int IW = $clog2(NUM_STAGES);
   localparam int TW = $clog2(STALL_TIMEOUT + 1);

   state_t                  state;
   logic [IW-1:0]           win_idx;
   logic                    win_valid;
   logic [IW-1:0]           k_cur;
   logic [3:0]              hold_cnt;
   logic [TW-1:0]           tcnt;
   logic [NUM_STAGES-1:0]   flush_mask;
   logic [NUM_STAGES-1:0]   stall_raw;
   logic                    capture;
   logic                    any_stall;

   pipe_ctrl_prio_enc #(
      .N  (NUM_STAGES),
      .IW (IW)
   ) u_prio_enc (
      .req   (flush_req),
      .idx   (win_idx),
      .valid (win_valid)
   );

   // A younger flush arriving while an older one is held is already covered by it.
   assign capture = win_valid && ((state == ST_RUN) || (win_idx >= k_cur));

   always_comb begin
      logic acc;
      acc        = 1'b0;
      stall_raw  = '0;
      flush_mask = '0;
      for (int j = NUM_STAGES - 1; j >= 0; j--) begin
         acc          = acc | stallreq[j];
         stall_raw[j] = acc;
         flush_mask[j] = (j <= int'(win_idx));
      end
   end

   always_comb begin
      stall  = (rst || (|flush_req) || (state == ST_FLUSH)) ? '0 : stall_raw;
      bubble = '0;
      for (int j = 1; j < NUM_STAGES; j++) begin
         bubble[j] = stall[j-1] & ~stall[j];
      end
   end

   assign any_stall = |stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_RUN;
         k_cur          <= '0;
         hold_cnt       <= '0;
         flush          <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else if (capture) begin
         state          <= ST_FLUSH;
         k_cur          <= win_idx;
         hold_cnt       <= 4'd1;
         flush          <= flush_mask;
         redirect_valid <= 1'b1;
         redirect_pc    <= flush_pc_in[win_idx*PC_W +: PC_W];
      end else begin
         redirect_valid <= 1'b0;
         if (state == ST_FLUSH) begin
            if (hold_cnt == 4'(FLUSH_HOLD)) begin
               state    <= ST_RUN;
               hold_cnt <= '0;
               flush    <= '0;
            end else begin
               hold_cnt <= hold_cnt + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt          <= '0;
         stall_timeout <= 1'b0;
      end else if (any_stall) begin
         if (tcnt != TW'(STALL_TIMEOUT)) tcnt <= tcnt + 1'b1;
         if (tcnt >= TW'(STALL_TIMEOUT - 1)) stall_timeout <= 1'b1;
      end else begin
         tcnt <= '0;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_flush_count  <= '0;
      end else begin
         if (any_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (redirect_valid) perf_flush_count <= perf_flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed self-checking bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;
   import pipe_ctrl_pkg::*;

   localparam int NS = 5;
   localparam int PW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [NS-1:0]    stallreq;
   logic [NS-1:0]    flush_req;
   logic [NS*PW-1:0] flush_pc_in;
   logic [NS-1:0]    stall;
   logic [NS-1:0]    bubble;
   logic [NS-1:0]    flush;
   logic             redirect_valid;
   logic [PW-1:0]    redirect_pc;
   logic             stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]      perf_stall_cycles;
   logic [31:0]      perf_flush_count;
`endif

   int checks = 0;
   int errors = 0;

   pipe_ctrl_unit #(
      .NUM_STAGES    (NS),
      .PC_W          (PW),
      .FLUSH_HOLD    (2),
      .STALL_TIMEOUT (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stallreq       (stallreq),
      .flush_req      (flush_req),
      .flush_pc_in    (flush_pc_in),
      .stall          (stall),
      .bubble         (bubble),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_timeout  (stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_count  (perf_flush_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_pc(input int k, input logic [PW-1:0] pc);
      flush_pc_in[k*PW +: PW] = pc;
   endtask

   initial begin
      rst         = 1'b1;
      stallreq    = 5'b00100;
      flush_req   = '0;
      flush_pc_in = '0;
      #1;
      check("rst_stall", stall, 5'b0);
      check("rst_bubble", bubble, 5'b0);
      check("rst_flush", flush, 5'b0);
      check("rst_rv", redirect_valid, 1'b0);
      check("rst_rpc", redirect_pc, 32'h0);
      check("rst_tmo", stall_timeout, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b0;
      stallreq = '0;

      // 1: stall fan-down and bubble edge, same cycle
      @(negedge clk);
      stallreq = 5'b00100;
      #1;
      check("s1_stall", stall, 5'b00111);
      check("s1_bubble", bubble, 5'b01000);
      @(negedge clk);
      stallreq = '0;
      #1;
      check("s1_stall_clr", stall, 5'b0);
      check("s1_bubble_clr", bubble, 5'b0);

      // 2: single flush from stage 3, held two cycles
      @(negedge clk);
      flush_req = 5'b01000;
      set_pc(3, 32'h8000_0100);
      #1;
      check("s2_latency", flush, 5'b0);
      @(negedge clk);
      flush_req = '0;
      #1;
      check("s2_flush1", flush, 5'b01111);
      check("s2_rv1", redirect_valid, 1'b1);
      check("s2_rpc", redirect_pc, 32'h8000_0100);
      @(negedge clk);
      check("s2_flush2", flush, 5'b01111);
      check("s2_rv2", redirect_valid, 1'b0);
      @(negedge clk);
      check("s2_flush_end", flush, 5'b0);
      check("s2_state", dut.state, ST_RUN);
`ifdef PIPE_CTRL_PERF_EN
      check("s2_perf_flush", perf_flush_count, 32'd1);
`endif

      // 3: flush beats stall in the request cycle
      @(negedge clk);
      stallreq  = 5'b10000;
      flush_req = 5'b00100;
      set_pc(2, 32'h0000_2000);
      #1;
      check("s3_stall", stall, 5'b0);
      check("s3_bubble", bubble, 5'b0);
      @(negedge clk);
      stallreq = 5'b00001;
      // 4: younger flush during FLUSH(k=2) is ignored
      flush_req = 5'b00010;
      set_pc(1, 32'h0000_1000);
      #1;
      check("s3_flush", flush, 5'b00111);
      check("s3_rv", redirect_valid, 1'b1);
      check("s4_stall_forced", stall, 5'b0);
      @(negedge clk);
      flush_req = 5'b01000;
      set_pc(3, 32'h0000_3000);
      #1;
      check("s4_ign_flush", flush, 5'b00111);
      check("s4_ign_rv", redirect_valid, 1'b0);
      check("s4_ign_rpc", redirect_pc, 32'h0000_2000);
      @(negedge clk);
      flush_req = '0;
      stallreq  = '0;
      #1;
      check("s4_re_flush", flush, 5'b01111);
      check("s4_re_rv", redirect_valid, 1'b1);
      check("s4_re_rpc", redirect_pc, 32'h0000_3000);
      @(negedge clk);
      check("s4_hold", flush, 5'b01111);
      check("s4_hold_rv", redirect_valid, 1'b0);
      @(negedge clk);
      check("s4_end", flush, 5'b0);

      // 5: stall timeout after 8 consecutive stall cycles, sticky
      stallreq = 5'b00010;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 7) check("s5_tmo_early", stall_timeout, 1'b0);
      end
      check("s5_tmo_set", stall_timeout, 1'b1);
      check("s5_stall_unchanged", stall, 5'b00011);
      stallreq = '0;
      @(negedge clk);
      check("s5_tmo_sticky", stall_timeout, 1'b1);
`ifdef PIPE_CTRL_PERF_EN
      check("s5_perf_stall", perf_stall_cycles, 32'd9);
      check("s5_perf_flush", perf_flush_count, 32'd3);
`endif
      rst = 1'b1;
      #1;
      check("s5_tmo_rst", stall_timeout, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // 6: async reset in the second hold cycle
      @(negedge clk);
      flush_req = 5'b10000;
      set_pc(4, 32'h0000_5000);
      @(negedge clk);
      flush_req = '0;
      #1;
      check("s6_flush1", flush, 5'b11111);
      @(negedge clk);
      stallreq = 5'b00100;
      #2;
      rst = 1'b1;
      #1;
      check("s6_flush", flush, 5'b0);
      check("s6_rv", redirect_valid, 1'b0);
      check("s6_stall", stall, 5'b0);
      check("s6_bubble", bubble, 5'b0);
      check("s6_rpc", redirect_pc, 32'h0);
      @(negedge clk);
      rst      = 1'b0;
      stallreq = '0;
      @(negedge clk);
      check("s6_state", dut.state, ST_RUN);
      check("s6_flush_after", flush, 5'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
